ldst_unit: RTL and testbench
============================

LDST_UNIT -- requirements
Module: ldst_unit

Interface
REQ-001 Parameter: XLEN, 32, data/address width; only 32 is supported.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset; asynchronous, active-low.
REQ-004 req_valid  in  1  core load/store request valid.
REQ-005 req_ready  out  1  unit accepts the request this cycle.
REQ-006 req_wen  in  1  1=store, 0=load.
REQ-007 req_size  in  2  0=byte, 1=half, 2=word; 3 is illegal.
REQ-008 req_signed  in  1  load sign-extend (1) / zero-extend (0); ignored for stores.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  32  store data, right-justified.
REQ-011 resp_valid  out  1  response valid.
REQ-012 resp_ready  in  1  core accepts the response.
REQ-013 resp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-014 resp_err  out  1  misaligned access or illegal size.
REQ-015 bus_req, bus_wen  out  1 each  uib master strobes.
REQ-016 bus_mode  out  3  lane mode: byte 3'b001, half 3'b011, word 3'b111.
REQ-017 bus_addr  out  32; bus_dat_i  out  32 (to slave); bus_dat_o  in  32 (from slave, raw lanes).

Function
REQ-018 FSM states: IDLE, ISSUE, CAPTURE, RESP; req_ready=1 only in IDLE.
REQ-019 IDLE, req_valid=1: latch addr/size/signed/wen/wdata; go to ISSUE if aligned, else to RESP with resp_err=1.
REQ-020 Aligned: byte any address; half addr[0]=0; word addr[1:0]=0; size 3 is always an error.
REQ-021 Error path: no bus activity; resp_rdata=0.
REQ-022 ISSUE (exactly one cycle): bus_req=1, bus_wen=latched wen, bus_addr=latched addr, bus_mode per REQ-016, bus_dat_i=wdata shifted left by 8*addr[1:0], masked to the active lanes.
REQ-023 Outside ISSUE, bus_req, bus_wen, bus_mode, bus_addr and bus_dat_i SHALL all be 0.
REQ-024 ISSUE -> CAPTURE for loads, ISSUE -> RESP for stores.
REQ-025 CAPTURE (the cycle after ISSUE; slave read latency fixed at 1): shift bus_dat_o right by 8*addr[1:0], keep 8/16/32 bits, sign- or zero-extend, register into resp_rdata, go to RESP.
REQ-026 RESP: resp_valid=1; resp_rdata and resp_err stay stable until resp_ready=1; then go to IDLE.
REQ-027 Response latency from the accept edge: load 3 cycles, store 2 cycles, error 1 cycle; no new accept in RESP.
REQ-028 resp_valid and resp_err are 0 in every state except RESP.
REQ-029 req_* inputs are ignored outside IDLE.

Reset
REQ-030 rst=0 SHALL immediately force state IDLE, all outputs 0 except req_ready=1, and clear the latched request.
REQ-031 Reset during ISSUE SHALL deassert bus_req/bus_wen combinationally from reset, with no further bus cycle and no response.

Structure
REQ-032 Shared package ldst_pkg holds: the size encoding, the bus_mode constants, the FSM state enum, and XLEN.
REQ-033 Sub-module ld_align: combinational lane shift, size mask and extension for the load path; instantiated once.

Verification
REQ-034 Store word 0xDEADBEEF @0x10 -> one ISSUE cycle with bus_mode=3'b111, bus_dat_i=0xDEADBEEF, bus_wen=1; resp_valid 2 cycles after accept; resp_rdata=0, resp_err=0.
REQ-035 Memory word 0x80000000 @0x10; signed byte load @0x13 -> resp_rdata=0xFFFFFF80; unsigned -> 0x00000080.
REQ-036 Store half 0xBEEF @0x12 then unsigned half load @0x12 -> bus_dat_i=0xBEEF0000, bus_mode=3'b011; resp_rdata=0x0000BEEF 3 cycles after the load accept.
REQ-037 Word load @0x2 and half load @0x1 -> bus_req never asserted; resp_err=1 one cycle after accept; resp_rdata=0.
REQ-038 Load with resp_ready held low 3 cycles -> resp_valid/resp_rdata held stable; req_ready=0 until the cycle after the handshake.
REQ-039 rst asserted during ISSUE of a store -> bus_wen=0 immediately; after release, IDLE with req_ready=1 and no resp_valid.

Source files
------------

// File: rtl/ldst_pkg.sv
// ----------------------------------------------------------------------------
// ldst_pkg -- shared definitions for the load/store unit.
//   XLEN        : data/address width (only 32 is supported)
//   size_e      : request size encoding (byte/half/word/illegal)
//   MODE_*      : bus lane-mode constants driven on bus_mode
//   state_e     : control FSM states
//   is_aligned / size_to_mode / size_to_lanes : small decode helpers
// ----------------------------------------------------------------------------
package ldst_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'd0,
    SZ_HALF    = 2'd1,
    SZ_WORD    = 2'd2,
    SZ_ILLEGAL = 2'd3
  } size_e;

  localparam logic [2:0] MODE_BYTE = 3'b001;
  localparam logic [2:0] MODE_HALF = 3'b011;
  localparam logic [2:0] MODE_WORD = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_RESP
  } state_e;

  // An illegal size is never aligned, so it always takes the error path.
  function automatic logic is_aligned(input size_e size, input logic [1:0] off);
    logic ok;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~off[0];
      SZ_WORD: ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [2:0] size_to_mode(input size_e size);
    logic [2:0] mode;
    case (size)
      SZ_BYTE: mode = MODE_BYTE;
      SZ_HALF: mode = MODE_HALF;
      SZ_WORD: mode = MODE_WORD;
      default: mode = 3'b000;
    endcase
    return mode;
  endfunction

  // Byte-lane enables for an access starting at lane 0.
  function automatic logic [3:0] size_to_lanes(input size_e size);
    logic [3:0] lanes;
    case (size)
      SZ_BYTE: lanes = 4'b0001;
      SZ_HALF: lanes = 4'b0011;
      SZ_WORD: lanes = 4'b1111;
      default: lanes = 4'b0000;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/ld_align.sv
// ----------------------------------------------------------------------------
// ld_align -- combinational load-data alignment.
//   i_data   : raw 32-bit word from the slave (all lanes)
//   i_offset : byte offset of the access (addr[1:0])
//   i_size   : access size
//   i_signed : 1 = sign-extend, 0 = zero-extend
//   o_data   : right-justified, extended load result (0 for illegal size)
// ----------------------------------------------------------------------------
module ld_align
  import ldst_pkg::*;
(
  input  logic [XLEN-1:0] i_data,
  input  logic [1:0]      i_offset,
  input  size_e           i_size,
  input  logic            i_signed,
  output logic [XLEN-1:0] o_data
);

  logic [XLEN-1:0] w_shifted;

  assign w_shifted = i_data >> {i_offset, 3'b000};

  always_comb begin
    o_data = '0;
    case (i_size)
      SZ_BYTE: o_data = {{24{i_signed & w_shifted[7]}},  w_shifted[7:0]};
      SZ_HALF: o_data = {{16{i_signed & w_shifted[15]}}, w_shifted[15:0]};
      SZ_WORD: o_data = w_shifted;
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/ldst_unit.sv
// ----------------------------------------------------------------------------
// ldst_unit -- single-outstanding load/store unit bridging a core request
// channel to a uib bus master with a fixed 1-cycle slave read latency.
//   clk, rst                  : clock, async active-low reset
//   req_valid/req_ready       : request handshake (ready only in IDLE)
//   req_wen/size/signed/addr/wdata : request fields
//   resp_valid/resp_ready     : response handshake
//   resp_rdata/resp_err       : extended load data / misalign-or-illegal flag
//   bus_req/wen/mode/addr/dat_i : bus master outputs, nonzero only in ISSUE
//   bus_dat_o                 : raw read lanes from the slave
// Latency from the accept edge: load 3, store 2, error 1 cycles.
// ----------------------------------------------------------------------------
module ldst_unit #(
  parameter int XLEN = 32  // only 32 is supported
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_wen,
  input  logic [1:0]      req_size,
  input  logic            req_signed,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            bus_req,
  output logic            bus_wen,
  output logic [2:0]      bus_mode,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_dat_i,
  input  logic [XLEN-1:0] bus_dat_o
);

  import ldst_pkg::*;

  state_e          r_state, w_state_nxt;
  logic [XLEN-1:0] r_addr, r_wdata, r_rdata;
  size_e           r_size;
  logic            r_signed, r_wen, r_err;

  logic            w_accept, w_aligned;
  logic [3:0]      w_lanes;
  logic [XLEN-1:0] w_lane_mask, w_ld_data;

  assign w_accept  = (r_state == ST_IDLE) && req_valid;
  assign w_aligned = is_aligned(size_e'(req_size), req_addr[1:0]);

  // Active byte lanes of the latched access, expanded to a bit mask.
  assign w_lanes = size_to_lanes(r_size) << r_addr[1:0];
  always_comb begin
    w_lane_mask = '0;
    for (int i = 0; i < 4; i++) w_lane_mask[8*i +: 8] = {8{w_lanes[i]}};
  end

  ld_align u_ld_align (
    .i_data   (bus_dat_o),
    .i_offset (r_addr[1:0]),
    .i_size   (r_size),
    .i_signed (r_signed),
    .o_data   (w_ld_data)
  );

  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // NOTE: the latched request is reset too, so no stale access survives a reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_size   <= SZ_BYTE;
      r_signed <= 1'b0;
      r_wen    <= 1'b0;
      r_err    <= 1'b0;
    end else if (w_accept) begin
      r_addr   <= req_addr;
      r_wdata  <= req_wdata;
      r_rdata  <= '0;          // stores and errors answer with zero data
      r_size   <= size_e'(req_size);
      r_signed <= req_signed;
      r_wen    <= req_wen;
      r_err    <= ~w_aligned;
    end else if (r_state == ST_CAPTURE) begin
      r_rdata  <= w_ld_data;   // slave data is valid exactly this cycle
    end
  end

  // All outputs decode from the state register, so an async reset clears
  // the bus strobes immediately without waiting for a clock edge.
  // NOTE: every output gets a default first; a missed branch would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_err    = 1'b0;
    resp_rdata  = '0;
    bus_req     = 1'b0;
    bus_wen     = 1'b0;
    bus_mode    = 3'b000;
    bus_addr    = '0;
    bus_dat_i   = '0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_nxt = w_aligned ? ST_ISSUE : ST_RESP;
      end
      ST_ISSUE: begin
        bus_req     = 1'b1;
        bus_wen     = r_wen;
        bus_mode    = size_to_mode(r_size);
        bus_addr    = r_addr;
        bus_dat_i   = (r_wdata << {r_addr[1:0], 3'b000}) & w_lane_mask;
        w_state_nxt = r_wen ? ST_RESP : ST_CAPTURE;
      end
      ST_CAPTURE: w_state_nxt = ST_RESP;
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_err   = r_err;
        resp_rdata = r_rdata;
        if (resp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ldst_unit.sv
// ----------------------------------------------------------------------------
// tb_ldst_unit -- self-checking bench for ldst_unit. A byte-lane slave model
// answers bus cycles with 1-cycle read latency; a reference memory model
// predicts every response, which is queued at drive time and popped when the
// unit answers.
// ----------------------------------------------------------------------------
module tb_ldst_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        bus_req, bus_wen;
  logic [2:0]  bus_mode;
  logic [31:0] bus_addr, bus_dat_i, bus_dat_o;

  always #5 clk = ~clk;

  ldst_unit #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wen    (req_wen),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .bus_req    (bus_req),
    .bus_wen    (bus_wen),
    .bus_mode   (bus_mode),
    .bus_addr   (bus_addr),
    .bus_dat_i  (bus_dat_i),
    .bus_dat_o  (bus_dat_o)
  );

  // Slave: 16 words, writes only the lanes named by bus_mode at the offset,
  // read data valid only in the cycle after the request (junk otherwise).
  logic [31:0] mem [16];
  logic        mem_clr;

  always @(posedge clk) begin
    logic [31:0] w;
    int nb;
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      bus_dat_o <= $urandom;
    end else if (bus_req) begin
      nb = (bus_mode == 3'b001) ? 1 : (bus_mode == 3'b011) ? 2 : 4;
      if (bus_wen) begin
        w = mem[bus_addr[5:2]];
        for (int k = 0; k < 4; k++)
          if (k >= int'(bus_addr[1:0]) && k < int'(bus_addr[1:0]) + nb) w[8*k +: 8] = bus_dat_i[8*k +: 8];
        mem[bus_addr[5:2]] <= w;
        bus_dat_o <= $urandom;
      end else begin
        bus_dat_o <= mem[bus_addr[5:2]];
      end
    end else begin
      bus_dat_o <= $urandom;
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nbus;
    logic [2:0]  mode;
    logic [31:0] dat_i;
    logic        wen;
    logic [31:0] addr;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] model_mem [16];
  int          n_checks = 0;
  int          n_errors = 0;

  // One complete transaction: predict, drive, observe, compare, handshake.
  task automatic do_req(input logic wen, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int hold, input string tag, output txn_t obs);
    txn_t        e;
    int          off, nbytes, idx;
    bit          ok;
    logic [31:0] v;
    off    = int'(addr[1:0]);
    idx    = int'(addr[5:2]);
    nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
    ok     = (nbytes != 0) && ((off % nbytes) == 0);
    e.err  = !ok;
    e.lat  = !ok ? 1 : (wen ? 2 : 3);
    e.nbus = ok ? 1 : 0;
    e.mode = (nbytes == 1) ? 3'b001 : (nbytes == 2) ? 3'b011 : 3'b111;
    e.wen  = wen;
    e.addr = addr;
    e.dat_i = '0;
    for (int k = 0; k < 4; k++)
      if (k >= off && k < off + nbytes) e.dat_i[8*k +: 8] = wdata[8*(k-off) +: 8];
    e.rdata = '0;
    if (ok && !wen) begin
      v = '0;
      for (int b = 0; b < nbytes; b++) v[8*b +: 8] = model_mem[idx][8*(off+b) +: 8];
      if (sgn && v[8*nbytes-1])
        for (int b = nbytes; b < 4; b++) v[8*b +: 8] = 8'hFF;
      e.rdata = v;
    end
    if (ok && wen)
      for (int k = 0; k < 4; k++)
        if (k >= off && k < off + nbytes) model_mem[idx][8*k +: 8] = e.dat_i[8*k +: 8];
    exp_q.push_back(e);

    @(negedge clk);
    req_valid  = 1'b1;
    req_wen    = wen;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    resp_ready = (hold == 0);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL %s req_ready before accept: got %b exp 1", tag, req_ready);
    end
    @(posedge clk);
    #1;
    // Keep presenting junk requests; the unit must ignore them until IDLE.
    req_wen   = $urandom_range(0, 1);
    req_size  = 2'($urandom_range(0, 3));
    req_addr  = $urandom;
    req_wdata = $urandom;

    obs.lat = 1; obs.nbus = 0; obs.mode = '0; obs.dat_i = '0; obs.wen = 1'b0; obs.addr = '0;
    @(negedge clk);
    forever begin
      if (bus_req === 1'b1) begin
        obs.nbus++;
        obs.mode = bus_mode; obs.dat_i = bus_dat_i; obs.wen = bus_wen; obs.addr = bus_addr;
      end
      if (resp_valid === 1'b1 || obs.lat >= 8) break;
      @(posedge clk);
      obs.lat++;
      @(negedge clk);
    end
    req_valid  = 1'b0;
    obs.rdata  = resp_rdata;
    obs.err    = resp_err;

    n_checks++;
    if (resp_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL %s resp timeout: got resp_valid %b exp 1 within 8 cycles", tag, resp_valid);
    end
    e = exp_q.pop_front();
    n_checks++;
    if (obs.lat != e.lat) begin
      n_errors++;
      $display("FAIL %s latency: got %0d exp %0d", tag, obs.lat, e.lat);
    end
    n_checks++;
    if (obs.rdata !== e.rdata) begin
      n_errors++;
      $display("FAIL %s rdata: got %h exp %h", tag, obs.rdata, e.rdata);
    end
    n_checks++;
    if (obs.err !== e.err) begin
      n_errors++;
      $display("FAIL %s err: got %b exp %b", tag, obs.err, e.err);
    end
    n_checks++;
    if (obs.nbus != e.nbus) begin
      n_errors++;
      $display("FAIL %s bus cycles: got %0d exp %0d", tag, obs.nbus, e.nbus);
    end
    if (e.nbus != 0) begin
      n_checks++;
      if ({obs.mode, obs.dat_i, obs.wen, obs.addr} !== {e.mode, e.dat_i, e.wen, e.addr}) begin
        n_errors++;
        $display("FAIL %s bus fields: got mode %b dat %h wen %b addr %h exp mode %b dat %h wen %b addr %h",
                 tag, obs.mode, obs.dat_i, obs.wen, obs.addr, e.mode, e.dat_i, e.wen, e.addr);
      end
    end

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      n_checks++;
      if ({resp_valid, req_ready, resp_err, resp_rdata} !== {1'b1, 1'b0, obs.err, obs.rdata}) begin
        n_errors++;
        $display("FAIL %s hold cycle %0d: got valid %b ready %b err %b rdata %h exp valid 1 ready 0 err %b rdata %h",
                 tag, h, resp_valid, req_ready, resp_err, resp_rdata, obs.err, obs.rdata);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({resp_valid, req_ready} !== 2'b01) begin
      n_errors++;
      $display("FAIL %s after handshake: got valid %b ready %b exp valid 0 ready 1", tag, resp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; mem_clr = 1'b1;
    req_valid = 1'b0; req_wen = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    for (int i = 0; i < 16; i++) model_mem[i] = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset req_ready: got %b exp 1", req_ready);
    end
    n_checks++;
    if ({resp_valid, resp_err, resp_rdata, bus_req, bus_wen, bus_mode, bus_addr, bus_dat_i} !== '0) begin
      n_errors++;
      $display("FAIL reset outputs: got valid %b err %b rdata %h breq %b bwen %b mode %b addr %h dat %h exp all 0",
               resp_valid, resp_err, resp_rdata, bus_req, bus_wen, bus_mode, bus_addr, bus_dat_i);
    end
    rst = 1'b1; mem_clr = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({req_ready, resp_valid, bus_req} !== 3'b100) begin
      n_errors++;
      $display("FAIL reset release idle: got ready %b valid %b breq %b exp 1 0 0", req_ready, resp_valid, bus_req);
    end
  endtask

  task automatic test_store_word();
    txn_t o;
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, "st_word", o);
    n_checks++;
    if ({o.mode, o.dat_i, o.wen, o.rdata, o.err} !== {3'b111, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0} || o.lat != 2) begin
      n_errors++;
      $display("FAIL st_word fixed: got mode %b dat %h wen %b rdata %h err %b lat %0d exp 111 deadbeef 1 0 0 2",
               o.mode, o.dat_i, o.wen, o.rdata, o.err, o.lat);
    end
  endtask

  task automatic test_load_byte();
    txn_t o;
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h80000000, 0, "st_80", o);
    do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0, "ld_b_s", o);
    n_checks++;
    if (o.rdata !== 32'hFFFFFF80) begin
      n_errors++;
      $display("FAIL ld_b_s fixed: got %h exp ffffff80", o.rdata);
    end
    do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 0, "ld_b_u", o);
    n_checks++;
    if (o.rdata !== 32'h00000080) begin
      n_errors++;
      $display("FAIL ld_b_u fixed: got %h exp 00000080", o.rdata);
    end
  endtask

  task automatic test_half();
    txn_t o;
    do_req(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000BEEF, 0, "st_h", o);
    n_checks++;
    if ({o.dat_i, o.mode} !== {32'hBEEF0000, 3'b011}) begin
      n_errors++;
      $display("FAIL st_h fixed: got dat %h mode %b exp beef0000 011", o.dat_i, o.mode);
    end
    do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 0, "ld_h_u", o);
    n_checks++;
    if (o.rdata !== 32'h0000BEEF || o.lat != 3) begin
      n_errors++;
      $display("FAIL ld_h_u fixed: got %h lat %0d exp 0000beef lat 3", o.rdata, o.lat);
    end
    do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 0, "ld_h_s", o);
    n_checks++;
    if (o.rdata !== 32'hFFFFBEEF) begin
      n_errors++;
      $display("FAIL ld_h_s fixed: got %h exp ffffbeef", o.rdata);
    end
  endtask

  task automatic test_errors();
    txn_t o;
    logic [31:0] addrs [4] = '{32'h2, 32'h1, 32'h0, 32'h6};
    logic [1:0]  sizes [4] = '{2'd2, 2'd1, 2'd3, 2'd2};
    logic        wens  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      do_req(wens[i], sizes[i], 1'b1, addrs[i], 32'hFFFFFFFF, 0, $sformatf("err%0d", i), o);
      n_checks++;
      if (o.nbus != 0 || o.err !== 1'b1 || o.rdata !== 32'h0 || o.lat != 1) begin
        n_errors++;
        $display("FAIL err%0d fixed: got nbus %0d err %b rdata %h lat %0d exp 0 1 0 1", i, o.nbus, o.err, o.rdata, o.lat);
      end
    end
  endtask

  task automatic test_backpressure();
    txn_t o;
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 3, "ld_hold", o);
    n_checks++;
    if (o.rdata !== 32'hBEEF0000) begin
      n_errors++;
      $display("FAIL ld_hold fixed: got %h exp beef0000", o.rdata);
    end
  endtask

  task automatic test_back_to_back();
    txn_t o;
    for (int i = 0; i < 40; i++)
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             32'($urandom_range(0, 63)), $urandom, int'($urandom_range(0, 2)), $sformatf("rnd%0d", i), o);
  endtask

  task automatic test_reset_issue();
    txn_t o;
    do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h11111111, 0, "st_pre", o);
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h20; req_wdata = 32'h22222222;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n_checks++;
    if ({bus_req, bus_wen} !== 2'b11) begin
      n_errors++;
      $display("FAIL rst_issue precondition: got breq %b bwen %b exp 1 1", bus_req, bus_wen);
    end
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if ({bus_req, bus_wen, req_ready, resp_valid} !== 4'b0010) begin
      n_errors++;
      $display("FAIL rst_issue immediate: got breq %b bwen %b ready %b valid %b exp 0 0 1 0",
               bus_req, bus_wen, req_ready, resp_valid);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if ({req_ready, resp_valid, bus_req} !== 3'b100) begin
        n_errors++;
        $display("FAIL rst_issue after %0d: got ready %b valid %b breq %b exp 1 0 0", i, req_ready, resp_valid, bus_req);
      end
    end
    n_checks++;
    if (mem[8] !== 32'h11111111) begin
      n_errors++;
      $display("FAIL rst_issue no write: got %h exp 11111111", mem[8]);
    end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_load_byte();
    test_half();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_reset_issue();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
